iter_div_dp: RTL
================

Name: iter_div_dp

Overview:
- Iterative repeated-subtraction divider datapath.
- It is the responder half of the lab start/zero/do_iter/ready control handshake. The control FSM issues do_iter and ready. This block executes one subtraction per do_iter and reports zero back to the FSM.
- It also captures the final quotient and remainder when ready is asserted and presents them with a one-cycle valid pulse.

Parameters:
- W, 8, operand/result width in bits (W >= 2).

Ports:
- clk  input  1  clock, all registers update on the rising edge.
- rst  input  1  asynchronous reset, active high.
- load  input  1  capture operands; the integrator drives it as start qualified by controller idle.
- dividend  input  W  dividend, sampled when load=1.
- divisor  input  W  divisor, sampled when load=1.
- do_iter  input  1  perform one iteration, from the control FSM.
- ready  input  1  operation finished, from the control FSM; triggers result capture.
- zero  output  1  status to the FSM: no further iteration possible.
- quotient  output  W  registered result quotient.
- remainder  output  W  registered result remainder.
- dbz  output  1  registered flag: the last result was a divide by zero.
- valid  output  1  one-cycle pulse: quotient, remainder and dbz were just updated.
- iter_err  output  1  sticky flag: do_iter was received while zero=1.

Behaviour:
- Internal registers:
  - rem_q[W], div_q[W], quo_q[W].
  - cnt_q[W], the iteration count, saturating at all ones.
  - cap_q, a delayed copy of ready capture used to generate valid.
- Reset (asynchronous, rst=1): every internal register and every output register clears to 0.
  - Outputs after reset: quotient=0, remainder=0, dbz=0, valid=0, iter_err=0.
  - zero=1, because div_q=0.
- zero is combinational from registers only: zero = (div_q == 0) | (rem_q < div_q), unsigned compare.
  - It is valid in the same cycle as FSM state s_initial, i.e. the cycle after load.
  - It has no combinational path from any input.
- load=1 at a rising edge:
  - rem_q<=dividend, div_q<=divisor, quo_q<=0, cnt_q<=0, iter_err<=0.
  - load has priority over do_iter and ready in the same cycle; those are ignored.
- do_iter=1, load=0, zero=0 at a rising edge:
  - rem_q<=rem_q-div_q. The subtraction is W bits and cannot underflow, because zero=0 guarantees rem_q>=div_q.
  - quo_q<=quo_q+1 and cnt_q<=cnt_q+1, both saturating at 2^W-1.
  - Latency from do_iter to the updated zero: 1 cycle.
- do_iter=1 while zero=1: datapath registers are unchanged and iter_err<=1.
  - iter_err stays set until the next load or reset.
- ready=1 at a rising edge (load=0): result capture.
  - Normal case: quotient<=quo_q, remainder<=rem_q, dbz<=0.
  - When div_q==0: quotient<=all ones, remainder<=rem_q (the original dividend), dbz<=1.
  - valid rises 1 cycle after the capture edge and stays high for exactly 1 cycle.
  - If ready is held for N cycles, the block captures N times and valid is high for N cycles.
- ready and do_iter in the same cycle: both actions occur. Capture uses the pre-iteration values.
- Result outputs hold their values between captures; only load-independent capture changes them.
- Reset mid-operation: all state is lost immediately (asynchronous), with no partial result and no valid pulse.
- Division by zero: the FSM must go s_initial -> s_final with 0 iterations, since zero=1 right after load.
- Iteration bound: quotient never exceeds 2^W-1. With divisor=1 and dividend=2^W-1 the block needs 255 iterations (W=8), and no saturation occurs in that case.

Test Plan:
- Normal division: dividend=17, divisor=5, load 1 cycle, FSM-driven.
  - zero=0 in s_initial; 3 do_iter cycles; zero=1 after the 3rd.
  - ready -> one cycle later valid=1, quotient=3, remainder=2, dbz=0, iter_err=0.
- Divisor zero: dividend=9, divisor=0.
  - zero=1 in the cycle after load; 0 do_iter.
  - Capture gives quotient=8'hFF, remainder=9, dbz=1, valid pulses once.
- Small dividend: dividend=3, divisor=7.
  - zero=1 immediately.
  - Capture gives quotient=0, remainder=3, dbz=0.
- Maximum iterations: dividend=255, divisor=1.
  - Exactly 255 do_iter pulses before zero=1.
  - quotient=255, remainder=0.
- Protocol abuse and priority:
  - do_iter forced while zero=1 -> iter_err=1 and registers unchanged.
  - load and do_iter in the same cycle (new 20/4) -> rem_q=20, iter_err cleared.
  - Result: 5 iterations, quotient=5, remainder=0.
- Async reset mid-iteration: assert rst between clock edges during 17/5 after 1 iteration.
  - Immediately zero=1, quotient=0, remainder=0, valid=0, iter_err=0.
  - No valid pulse follows rst deassertion.

Source files
------------

// File: rtl/iter_div_dp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : iter_div_dp                                                   |
// | Purpose  : Repeated-subtraction divider datapath. Responder half of the  |
// |            start/zero/do_iter/ready handshake: performs one subtraction  |
// |            per do_iter, reports zero to the control FSM, and captures    |
// |            quotient/remainder on ready with a one-cycle valid pulse.     |
// | Ports    : clk, rst (async, active high)                                 |
// |            load, dividend[W], divisor[W]  - operand capture              |
// |            do_iter, ready                 - from the control FSM         |
// |            zero                           - to the FSM, registers only   |
// |            quotient[W], remainder[W], dbz - registered result            |
// |            valid                          - result-updated pulse         |
// |            iter_err                       - sticky do_iter-while-zero    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module iter_div_dp #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  input  logic         do_iter,
  input  logic         ready,
  output logic         zero,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dbz,
  output logic         valid,
  output logic         iter_err
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  // Working registers
  logic [W-1:0] rem_q;
  logic [W-1:0] div_q;
  logic [W-1:0] quo_q;
  logic [W-1:0] cnt_q;
  logic         cap_q;

  // Decoded actions for this edge; load overrides everything else.
  logic         w_div_zero;
  logic         w_step;
  logic         w_bad_iter;
  logic         w_capture;

  // Status back to the FSM. Built only from registers so the FSM can sample
  // it in the cycle right after load without any input-to-output path.
  assign w_div_zero = (div_q == '0);
  assign zero       = w_div_zero | (rem_q < div_q);

  assign w_step     = ~load & do_iter & ~zero;
  assign w_bad_iter = ~load & do_iter &  zero;
  assign w_capture  = ~load & ready;

  // Iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= dividend;
      div_q <= divisor;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (w_step) begin
      // zero=0 guarantees rem_q >= div_q, so this cannot wrap.
      rem_q <= rem_q - div_q;
      if (quo_q != ALL_ONES) begin
        quo_q <= quo_q + 1'b1;
      end
      if (cnt_q != ALL_ONES) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Sticky protocol error: cleared only by a new load or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_err <= 1'b0;
    end else if (load) begin
      iter_err <= 1'b0;
    end else if (w_bad_iter) begin
      iter_err <= 1'b1;
    end
  end

  // Result capture. Uses the pre-iteration register values when ready and
  // do_iter coincide, since both read the same current-cycle state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else if (w_capture) begin
      quotient  <= w_div_zero ? ALL_ONES : quo_q;
      remainder <= rem_q;
      dbz       <= w_div_zero;
    end
  end

  // valid is high in exactly the cycle following each capture edge, so a
  // ready held for N cycles yields N consecutive valid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= 1'b0;
    end else begin
      cap_q <= w_capture;
    end
  end

  assign valid = cap_q;

endmodule
`default_nettype wire
